// File: rtl/kiwi_main_pkg.sv
// Shared constants and address decode helper for the Kiwi main-CPU bus glue.
package kiwi_main_pkg;

  localparam logic [3:0] ROM_TOP   = 4'hC;
  localparam logic [3:0] RAM_PAGE  = 4'hE;
  localparam logic [7:0] BANK_PAGE = 8'hF6;
  localparam logic [1:0] PAL_SEL   = 2'b10;
  localparam logic [3:0] VCTRL_MAX = 4'd4;
  localparam logic [2:0] VRAM_PAGE = 3'b110;
  localparam logic [3:0] IO_PAGE   = 4'hF;

  // One bit per decoded memory region.
  typedef struct packed {
    logic rom;
    logic vram;
    logic ram;
    logic vctrl;
    logic pal;
    logic bank;
  } sel_t;

  // Decode the Z80 address into region selects, qualified by a memory access.
  function automatic sel_t decode_sel(input logic [15:0] a, input logic wr_n, input logic acc);
    sel_t s;
    s.rom   = acc & (a[15:12] < ROM_TOP);
    s.vram  = acc & (a[15:13] == VRAM_PAGE);
    s.ram   = acc & (a[15:12] == RAM_PAGE);
    s.vctrl = acc & (a[15:12] == IO_PAGE) & (a[11:8] <= VCTRL_MAX);
    s.pal   = acc & (a[15:12] == IO_PAGE) & (a[11:10] == PAL_SEL);
    s.bank  = acc & (a[15:8] == BANK_PAGE) & ~wr_n;
    return s;
  endfunction

endpackage

// File: rtl/kiwi_shared_ram.sv
// True dual-port byte RAM shared between the main and sound CPUs.
// Synchronous read, one cycle latency, read-during-write returns old data.
module kiwi_shared_ram #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic [AW-1:0] addr0,
  input  logic [7:0]    din0,
  input  logic          we0,
  output logic [7:0]    q0,
  input  logic [AW-1:0] addr1,
  input  logic [7:0]    din1,
  input  logic          we1,
  output logic [7:0]    q1
);

  logic [7:0] mem_q [0:(2**AW)-1];
  logic [7:0] q0_q;
  logic [7:0] q1_q;

  // Write either port and register both read ports; contents are never reset.
  always_ff @(posedge clk) begin
    if (we0) begin
      mem_q[addr0] <= din0;
    end
    if (we1) begin
      mem_q[addr1] <= din1;
    end
    q0_q <= mem_q[addr0];
    q1_q <= mem_q[addr1];
  end

  assign q0 = q0_q;
  assign q1 = q1_q;

endmodule

// File: rtl/kiwi_main_bus.sv
// Kiwi main Z80 bus glue: chip selects, ROM banking, sound reset latch,
// vblank IRQ, wait-state gating and the shared RAM arbiter.
module kiwi_main_bus
  import kiwi_main_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen6,
  input  logic        LVBL,
  input  logic [8:0]  hcnt,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_dout,
  input  logic        mreq_n,
  input  logic        rfsh_n,
  input  logic        iorq_n,
  input  logic        wr_n,
  output logic [7:0]  cpu_din,
  output logic        cpu_cen,
  output logic        int_n,
  output logic        cpu_rnw,
  output logic [12:0] cpu_addr,
  output logic        vram_cs,
  output logic        vctrl_cs,
  output logic        pal_cs,
  input  logic [7:0]  vram_dout,
  input  logic [7:0]  pal_dout,
  output logic        rom_cs,
  output logic [16:0] rom_addr,
  input  logic [7:0]  rom_data,
  input  logic        rom_ok,
  output logic        snd_rstn,
  input  logic [12:0] shr_addr,
  input  logic [7:0]  shr_din,
  input  logic        shr_cs,
  input  logic        sub_rnw,
  output logic [7:0]  shr_dout,
  output logic        mshramen,
  output logic [7:0]  st_dout
);

  logic       mem_acc_s;
  sel_t       sel_now_s;
  sel_t       sel_d,      sel_q;
  logic [7:0] cpu_din_d,  cpu_din_q;
  logic [2:0] bank_d,     bank_q;
  logic       snd_rstn_d, snd_rstn_q;
  logic       vb_d,       vb_q;
  logic       int_n_d,    int_n_q;
  logic       msh_d,      msh_q;
  logic       ssh_d,      ssh_q;
  logic       vb_rise_s;
  logic       dev_busy_s;
  logic [7:0] ram_q0_s;
  logic       we0_s;
  logic       we1_s;
  logic       hcnt_unused;

  assign hcnt_unused = ^hcnt[8:2];

  assign mem_acc_s = ~mreq_n & rfsh_n;
  assign sel_now_s = decode_sel(A, wr_n, mem_acc_s);

  // Select register input and prioritised read-data mux into cpu_din.
  always_comb begin
    sel_d     = sel_now_s;
    cpu_din_d = 8'h00;
    if (sel_q.rom) begin
      cpu_din_d = rom_data;
    end else if (sel_q.ram) begin
      cpu_din_d = ram_q0_s;
    end else if (sel_q.vram | sel_q.vctrl) begin
      cpu_din_d = vram_dout;
    end else if (sel_q.pal) begin
      cpu_din_d = pal_dout;
    end else begin
      cpu_din_d = 8'h00;
    end
  end

  // Bank and sound-reset latch, loaded by a write to the bank page.
  always_comb begin
    bank_d     = bank_q;
    snd_rstn_d = snd_rstn_q;
    if (sel_q.bank) begin
      bank_d     = cpu_dout[2:0];
      snd_rstn_d = cpu_dout[4];
    end else begin
      bank_d     = bank_q;
      snd_rstn_d = snd_rstn_q;
    end
  end

  // Vblank IRQ: falling LVBL clears int_n, an interrupt acknowledge sets it and wins a tie.
  always_comb begin
    vb_d      = ~LVBL;
    vb_rise_s = ~LVBL & ~vb_q;
    int_n_d   = int_n_q;
    if (!iorq_n) begin
      int_n_d = 1'b1;
    end else if (vb_rise_s) begin
      int_n_d = 1'b0;
    end else begin
      int_n_d = int_n_q;
    end
  end

  // First-come shared RAM arbiter; the sub grant also looks at the incoming
  // main decode so a request arriving on the same clock goes to the main CPU.
  always_comb begin
    msh_d = msh_q;
    ssh_d = ssh_q;
    if (sel_q.ram & ~ssh_q) begin
      msh_d = 1'b1;
    end else if (!sel_q.ram) begin
      msh_d = 1'b0;
    end else begin
      msh_d = msh_q;
    end
    if (shr_cs & ~msh_q & ~sel_q.ram & ~sel_now_s.ram) begin
      ssh_d = 1'b1;
    end else if (!shr_cs) begin
      ssh_d = 1'b0;
    end else begin
      ssh_d = ssh_q;
    end
  end

  // All bus-glue state, cleared together by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q      <= '0;
      cpu_din_q  <= 8'h00;
      bank_q     <= 3'd0;
      snd_rstn_q <= 1'b0;
      vb_q       <= 1'b0;
      int_n_q    <= 1'b1;
      msh_q      <= 1'b0;
      ssh_q      <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      cpu_din_q  <= cpu_din_d;
      bank_q     <= bank_d;
      snd_rstn_q <= snd_rstn_d;
      vb_q       <= vb_d;
      int_n_q    <= int_n_d;
      msh_q      <= msh_d;
      ssh_q      <= ssh_d;
    end
  end

  assign dev_busy_s = (ssh_q & sel_q.ram) |
                      ((sel_q.vram | sel_q.vctrl) & (hcnt[1:0] != 2'd3));
  assign cpu_cen    = cen6 & ~dev_busy_s & ~(sel_q.rom & ~rom_ok);
  assign cpu_rnw    = wr_n | ~cpu_cen;
  assign cpu_addr   = A[12:0];
  assign rom_addr   = {(A[15] ? bank_q : {2'b00, A[14]}), A[13:0]};
  assign cpu_din    = cpu_din_q;
  assign int_n      = int_n_q;
  assign rom_cs     = sel_q.rom;
  assign vram_cs    = sel_q.vram;
  assign vctrl_cs   = sel_q.vctrl;
  assign pal_cs     = sel_q.pal;
  assign snd_rstn   = snd_rstn_q;
  assign mshramen   = msh_q;
  assign st_dout    = {3'b000, ~snd_rstn_q, 1'b0, bank_q};

  assign we0_s = msh_q & ~wr_n;
  assign we1_s = ssh_q & ~sub_rnw;

  kiwi_shared_ram #(.AW(AW)) u_shared_ram (
    .clk   (clk),
    .addr0 (A[AW-1:0]),
    .din0  (cpu_dout),
    .we0   (we0_s),
    .q0    (ram_q0_s),
    .addr1 (shr_addr[AW-1:0]),
    .din1  (shr_din),
    .we1   (we1_s),
    .q1    (shr_dout)
  );

endmodule

// File: tb/tb_kiwi_main_bus.sv
// Directed, table-driven bench for kiwi_main_bus.
module tb_kiwi_main_bus;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen6;
  logic        LVBL;
  logic [8:0]  hcnt;
  logic [15:0] A;
  logic [7:0]  cpu_dout;
  logic        mreq_n, rfsh_n, iorq_n, wr_n;
  logic [7:0]  cpu_din;
  logic        cpu_cen, int_n, cpu_rnw;
  logic [12:0] cpu_addr;
  logic        vram_cs, vctrl_cs, pal_cs;
  logic [7:0]  vram_dout, pal_dout;
  logic        rom_cs;
  logic [16:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rom_ok;
  logic        snd_rstn;
  logic [12:0] shr_addr;
  logic [7:0]  shr_din;
  logic        shr_cs, sub_rnw;
  logic [7:0]  shr_dout;
  logic        mshramen;
  logic [7:0]  st_dout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  kiwi_main_bus dut (
    .clk(clk), .rst(rst), .cen6(cen6), .LVBL(LVBL), .hcnt(hcnt), .A(A),
    .cpu_dout(cpu_dout), .mreq_n(mreq_n), .rfsh_n(rfsh_n), .iorq_n(iorq_n), .wr_n(wr_n),
    .cpu_din(cpu_din), .cpu_cen(cpu_cen), .int_n(int_n), .cpu_rnw(cpu_rnw),
    .cpu_addr(cpu_addr), .vram_cs(vram_cs), .vctrl_cs(vctrl_cs), .pal_cs(pal_cs),
    .vram_dout(vram_dout), .pal_dout(pal_dout), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .snd_rstn(snd_rstn), .shr_addr(shr_addr),
    .shr_din(shr_din), .shr_cs(shr_cs), .sub_rnw(sub_rnw), .shr_dout(shr_dout),
    .mshramen(mshramen), .st_dout(st_dout)
  );

  typedef struct {
    logic [15:0] a;
    logic        mreq_n;
    logic        rfsh_n;
    logic [3:0]  exp_sel;   // {rom, vram, vctrl, pal}
    logic [7:0]  exp_din;
  } vec_t;

  vec_t vecs [12];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // rom_data=11, vram_dout=22, pal_dout=33 throughout the table
    vecs[0]  = '{16'h0000, 1'b0, 1'b1, 4'b1000, 8'h11};
    vecs[1]  = '{16'hBFFF, 1'b0, 1'b1, 4'b1000, 8'h11};
    vecs[2]  = '{16'hC000, 1'b0, 1'b1, 4'b0100, 8'h22};
    vecs[3]  = '{16'hDFFF, 1'b0, 1'b1, 4'b0100, 8'h22};
    vecs[4]  = '{16'hF400, 1'b0, 1'b1, 4'b0010, 8'h22};
    vecs[5]  = '{16'hF500, 1'b0, 1'b1, 4'b0000, 8'h00};
    vecs[6]  = '{16'hF800, 1'b0, 1'b1, 4'b0001, 8'h33};
    vecs[7]  = '{16'hFBFF, 1'b0, 1'b1, 4'b0001, 8'h33};
    vecs[8]  = '{16'hF000, 1'b0, 1'b1, 4'b0010, 8'h22};
    vecs[9]  = '{16'h0000, 1'b1, 1'b1, 4'b0000, 8'h00};
    vecs[10] = '{16'h0000, 1'b0, 1'b0, 4'b0000, 8'h00};
    vecs[11] = '{16'hFC00, 1'b0, 1'b1, 4'b0000, 8'h00};

    rst = 1'b1; cen6 = 1'b1; LVBL = 1'b1; hcnt = 9'd3; A = 16'h0000;
    cpu_dout = 8'h00; mreq_n = 1'b1; rfsh_n = 1'b1; iorq_n = 1'b1; wr_n = 1'b1;
    vram_dout = 8'h22; pal_dout = 8'h33; rom_data = 8'h11; rom_ok = 1'b1;
    shr_addr = 13'h0000; shr_din = 8'h00; shr_cs = 1'b0; sub_rnw = 1'b1;

    // reset state
    step(3);
    chk("rst_int_n", int_n, 1'b1);
    chk("rst_snd_rstn", snd_rstn, 1'b0);
    chk("rst_st_dout", st_dout, 8'h10);
    chk("rst_mshramen", mshramen, 1'b0);
    chk("rst_cpu_din", cpu_din, 8'h00);
    chk("rst_rom_cs", rom_cs, 1'b0);
    rst = 1'b0;
    step(1);

    // decode and read mux table
    for (int i = 0; i < 12; i++) begin
      A = vecs[i].a; mreq_n = vecs[i].mreq_n; rfsh_n = vecs[i].rfsh_n;
      step(2);
      chk($sformatf("v%0d_rom_cs", i), rom_cs, vecs[i].exp_sel[3]);
      chk($sformatf("v%0d_vram_cs", i), vram_cs, vecs[i].exp_sel[2]);
      chk($sformatf("v%0d_vctrl_cs", i), vctrl_cs, vecs[i].exp_sel[1]);
      chk($sformatf("v%0d_pal_cs", i), pal_cs, vecs[i].exp_sel[0]);
      chk($sformatf("v%0d_cpu_din", i), cpu_din, vecs[i].exp_din);
      chk($sformatf("v%0d_cpu_addr", i), cpu_addr, vecs[i].a[12:0]);
    end
    mreq_n = 1'b1; rfsh_n = 1'b1;
    step(1);

    // bank write
    A = 16'hF600; cpu_dout = 8'h15; mreq_n = 1'b0; wr_n = 1'b0;
    step(3);
    mreq_n = 1'b1; wr_n = 1'b1;
    step(1);
    chk("bank_st_dout", st_dout, 8'h05);
    chk("bank_snd_rstn", snd_rstn, 1'b1);
    A = 16'h9234; #1;
    chk("bank_rom_addr", rom_addr, 17'h15234);
    A = 16'h4000; #1;
    chk("low_rom_addr", rom_addr, 17'h04000);

    // ROM stall
    rom_ok = 1'b0; rom_data = 8'h00; mreq_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk($sformatf("stall%0d_cpu_cen", i), cpu_cen, 1'b0);
    end
    chk("stall_cpu_rnw", cpu_rnw, 1'b1);
    rom_ok = 1'b1; rom_data = 8'hA5; #1;
    chk("rom_ok_cpu_cen", cpu_cen, 1'b1);
    step(1);
    chk("rom_cpu_din", cpu_din, 8'hA5);
    cen6 = 1'b0; #1;
    chk("rom_cen6_low", cpu_cen, 1'b0);
    cen6 = 1'b1; #1;
    chk("rom_cen6_high", cpu_cen, 1'b1);
    mreq_n = 1'b1;
    step(2);

    // vblank IRQ
    LVBL = 1'b0;
    step(2);
    chk("irq_assert", int_n, 1'b0);
    iorq_n = 1'b0;
    step(1);
    chk("irq_ack", int_n, 1'b1);
    iorq_n = 1'b1;
    step(3);
    chk("irq_no_rearm", int_n, 1'b1);
    LVBL = 1'b1;
    step(2);
    LVBL = 1'b0; iorq_n = 1'b0;
    step(1);
    chk("irq_tie_ack_wins", int_n, 1'b1);
    iorq_n = 1'b1;
    step(1);
    chk("irq_tie_after", int_n, 1'b1);

    // main writes shared RAM
    A = 16'hE010; cpu_dout = 8'h3C; mreq_n = 1'b0; wr_n = 1'b0;
    step(2);
    chk("mwr_mshramen", mshramen, 1'b1);
    chk("mwr_cpu_cen", cpu_cen, 1'b1);
    step(1);
    mreq_n = 1'b1; wr_n = 1'b1;
    step(2);
    chk("mwr_release", mshramen, 1'b0);

    // sub reads then writes
    shr_cs = 1'b1; sub_rnw = 1'b1; shr_addr = 13'h0010;
    step(1);
    chk("sub_rd_shr_dout", shr_dout, 8'h3C);
    shr_din = 8'h5A; sub_rnw = 1'b0;
    step(1);
    shr_cs = 1'b0; sub_rnw = 1'b1;
    step(1);
    A = 16'hE010; mreq_n = 1'b0; wr_n = 1'b1;
    step(2);
    chk("main_rd_cpu_din", cpu_din, 8'h5A);
    mreq_n = 1'b1;
    step(3);

    // simultaneous request: main wins
    A = 16'hE000; mreq_n = 1'b0; shr_cs = 1'b1; sub_rnw = 1'b1;
    step(2);
    chk("tie_mshramen", mshramen, 1'b1);
    chk("tie_cpu_cen", cpu_cen, 1'b1);
    mreq_n = 1'b1;
    step(3);
    chk("tie_release", mshramen, 1'b0);

    // sub owns RAM: main access waits
    mreq_n = 1'b0;
    step(1);
    chk("sub_own_cen0", cpu_cen, 1'b0);
    step(1);
    chk("sub_own_cen1", cpu_cen, 1'b0);
    chk("sub_own_msh", mshramen, 1'b0);
    shr_cs = 1'b0;
    step(1);
    chk("sub_drop_cen", cpu_cen, 1'b1);
    step(1);
    chk("sub_drop_msh", mshramen, 1'b1);
    mreq_n = 1'b1;
    step(2);

    // video wait slots
    A = 16'hC000; mreq_n = 1'b0; hcnt = 9'd0;
    step(1);
    for (int h = 0; h < 4; h++) begin
      hcnt = 9'(h); #1;
      chk($sformatf("vslot%0d_cpu_cen", h), cpu_cen, (h == 3) ? 1'b1 : 1'b0);
    end
    mreq_n = 1'b1; hcnt = 9'd3;
    step(2);

    // mid-operation reset
    A = 16'hE000; mreq_n = 1'b0;
    step(3);
    chk("mid_msh_before", mshramen, 1'b1);
    LVBL = 1'b1;
    step(1);
    LVBL = 1'b0;
    step(2);
    rst = 1'b1;
    step(1);
    chk("mid_rst_msh", mshramen, 1'b0);
    chk("mid_rst_st_dout", st_dout, 8'h10);
    chk("mid_rst_int_n", int_n, 1'b1);
    rst = 1'b0; mreq_n = 1'b1;
    step(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
